// File: rtl/pipe_mem_arbiter_if.sv
// ============================================================================
// Module   : pipe_mem_arbiter_if
// Purpose  : Bundles the core fetch/data ports and the unified memory port
//            seen by the pipeline memory arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface pipe_mem_arbiter_if;
    // Instruction-fetch side
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    // Memory-stage data side
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    // Pipeline stalls
    logic        stall_f;
    logic        stall_m;
    // Unified memory side
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        bus_err;

    // Arbiter view
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata,
               mem_rdata, mem_ack,
        output if_rdata, if_ready, dm_rdata, dm_ready, stall_f, stall_m,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata, bus_err
    );

    // Core plus memory environment view
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata,
               mem_rdata, mem_ack,
        input  if_rdata, if_ready, dm_rdata, dm_ready, stall_f, stall_m,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata, bus_err
    );
endinterface

`default_nettype wire

// File: rtl/pipe_mem_arbiter.sv
// ============================================================================
// Module   : pipe_mem_arbiter
// Purpose  : Serialises fetch and data requests onto one variable-latency
//            memory; data has priority, bounded by a burst limit, and a
//            watchdog force-completes hung transactions.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_mem_arbiter #(
    parameter int unsigned MAX_DATA_BURST = 4,
    parameter int unsigned TIMEOUT        = 255,
    parameter logic [31:0] ERR_DATA       = 32'h0
) (
    input  logic              clk,
    input  logic              reset,   // asynchronous, active-low
    pipe_mem_arbiter_if.slave bus
);

    localparam logic [3:0] c_BE_FULL   = 4'b1111;
    localparam logic [3:0] c_BURST_MAX = 4'(MAX_DATA_BURST);
    localparam logic [3:0] c_BURST_SAT = 4'hF;
    localparam logic [7:0] c_TIMEOUT   = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY_D = 2'd1,
        S_BUSY_I = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      r_state;
    logic [3:0]  r_burst_cnt;
    logic [7:0]  r_wd_cnt;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_if_rdata;
    logic [31:0] r_dm_rdata;
    logic        r_if_ready;
    logic        r_dm_ready;
    logic        r_bus_err;

    logic        w_grant_d;
    logic        w_timeout;
    logic        w_finish;
    logic [31:0] w_rd_value;

    // Data wins unless fetch is waiting and the data burst allowance is spent.
    assign w_grant_d  = bus.dm_req & (~bus.if_req | (r_burst_cnt < c_BURST_MAX));
    assign w_timeout  = (r_wd_cnt == c_TIMEOUT);
    assign w_finish   = bus.mem_ack | w_timeout;
    assign w_rd_value = bus.mem_ack ? bus.mem_rdata : ERR_DATA;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_burst_cnt <= '0;
            r_wd_cnt    <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_if_ready  <= 1'b0;
            r_dm_ready  <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_if_ready <= 1'b0;
            r_dm_ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!bus.if_req) begin
                        r_burst_cnt <= '0;
                    end
                    if (w_grant_d) begin
                        r_state     <= S_BUSY_D;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= bus.dm_we;
                        r_mem_be    <= bus.dm_we ? bus.dm_be : c_BE_FULL;
                        r_mem_addr  <= bus.dm_addr;
                        r_mem_wdata <= bus.dm_wdata;
                        r_wd_cnt    <= '0;
                        if (bus.if_req && (r_burst_cnt != c_BURST_SAT)) begin
                            r_burst_cnt <= r_burst_cnt + 4'd1;
                        end
                    end else if (bus.if_req) begin
                        r_state     <= S_BUSY_I;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_be    <= c_BE_FULL;
                        r_mem_addr  <= bus.if_addr;
                        r_mem_wdata <= '0;
                        r_wd_cnt    <= '0;
                        r_burst_cnt <= '0;
                    end
                end
                S_BUSY_D, S_BUSY_I: begin
                    if (w_finish) begin
                        r_state   <= S_DONE;
                        r_mem_req <= 1'b0;
                        // An ack arriving on the timeout cycle counts as a normal completion.
                        if (!bus.mem_ack) begin
                            r_bus_err <= 1'b1;
                        end
                        if (r_state == S_BUSY_D) begin
                            r_dm_ready <= 1'b1;
                            if (!r_mem_we) begin
                                r_dm_rdata <= w_rd_value;
                            end
                        end else begin
                            r_if_ready <= 1'b1;
                            r_if_rdata <= w_rd_value;
                        end
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_be    = r_mem_be;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.if_ready  = r_if_ready;
    assign bus.dm_rdata  = r_dm_rdata;
    assign bus.dm_ready  = r_dm_ready;
    assign bus.bus_err   = r_bus_err;

    // Reset gates the stalls so every output reads 0 while reset is held.
    assign bus.stall_f = reset & bus.if_req & ~r_if_ready;
    assign bus.stall_m = reset & bus.dm_req & ~r_dm_ready;

endmodule

`default_nettype wire

// File: tb/tb_pipe_mem_arbiter.sv
// ============================================================================
// Module   : tb_pipe_mem_arbiter
// Purpose  : Directed, table-driven bench for pipe_mem_arbiter with a
//            programmable-latency memory responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_mem_arbiter;

    localparam logic [31:0] c_ERR = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_mem_arbiter_if bus_if ();

    pipe_mem_arbiter #(
        .MAX_DATA_BURST (4),
        .TIMEOUT        (8),
        .ERR_DATA       (c_ERR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Memory responder: ack arrives mem_lat cycles after mem_req rises.
    int          mem_lat  = 1;
    bit          mem_hang = 1'b0;
    logic [31:0] rd_vals [0:63];
    int          rd_idx   = 0;
    int          mcnt     = 0;

    initial begin
        bus_if.mem_ack   = 1'b0;
        bus_if.mem_rdata = 32'h0BAD0BAD;
        forever begin
            @(posedge clk);
            #1;
            if (bus_if.mem_req) mcnt = mcnt + 1;
            else                mcnt = 0;
            if (!mem_hang && bus_if.mem_req && (mcnt == mem_lat + 1)) begin
                bus_if.mem_ack   = 1'b1;
                bus_if.mem_rdata = rd_vals[rd_idx % 64];
                rd_idx = rd_idx + 1;
            end else begin
                bus_if.mem_ack   = 1'b0;
                bus_if.mem_rdata = 32'h0BAD0BAD;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running required finished");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic bound_fail(input string nm);
        n_tests = n_tests + 1;
        n_fail  = n_fail + 1;
        $display("FAIL %s: got no completion required completion", nm);
    endtask

    typedef struct {
        bit          is_fetch;
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
        int          exp_cyc;
        logic [3:0]  exp_be;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [6];

    // One complete transaction on one side, checked against its vector.
    task automatic run_vec(input vec_t v, input int idx);
        int n;
        bit seen;
        mem_lat    = v.lat;
        mem_hang   = 1'b0;
        rd_vals[0] = v.rdata;
        rd_idx     = 0;
        @(negedge clk);
        if (v.is_fetch) begin
            bus_if.if_req  = 1'b1;
            bus_if.if_addr = v.addr;
        end else begin
            bus_if.dm_req   = 1'b1;
            bus_if.dm_we    = v.we;
            bus_if.dm_be    = v.be;
            bus_if.dm_addr  = v.addr;
            bus_if.dm_wdata = v.wdata;
        end
        #1;
        chk($sformatf("v%0d stall_high", idx),
            32'(v.is_fetch ? bus_if.stall_f : bus_if.stall_m), 32'd1);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 300) begin
            @(negedge clk);
            n = n + 1;
            if (n == 1) begin
                chk($sformatf("v%0d mem_req", idx), 32'(bus_if.mem_req), 32'd1);
                chk($sformatf("v%0d mem_we", idx), 32'(bus_if.mem_we), 32'(v.we));
                chk($sformatf("v%0d mem_be", idx), 32'(bus_if.mem_be), 32'(v.exp_be));
                chk($sformatf("v%0d mem_addr", idx), bus_if.mem_addr, v.addr);
                if (v.we) chk($sformatf("v%0d mem_wdata", idx), bus_if.mem_wdata, v.wdata);
            end
            if (v.is_fetch ? bus_if.if_ready : bus_if.dm_ready) begin
                seen = 1'b1;
                chk($sformatf("v%0d latency", idx), 32'(n), 32'(v.exp_cyc));
                chk($sformatf("v%0d rdata", idx),
                    v.is_fetch ? bus_if.if_rdata : bus_if.dm_rdata, v.exp_rd);
                chk($sformatf("v%0d stall_low", idx),
                    32'(v.is_fetch ? bus_if.stall_f : bus_if.stall_m), 32'd0);
                bus_if.if_req = 1'b0;
                bus_if.dm_req = 1'b0;
            end
        end
        if (!seen) begin
            bound_fail($sformatf("v%0d ready_timeout", idx));
            bus_if.if_req = 1'b0;
            bus_if.dm_req = 1'b0;
        end
    endtask

    initial begin
        int n;
        int d_at, i_at, f_at, got, pulses, rises, n1, n2;
        bit prev_req, exp_i;
        logic [31:0] v1, v2;

        // is_fetch we be addr wdata lat rdata exp_cyc exp_be exp_rd
        vecs[0] = '{1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 1, 32'hE3A01005, 3, 4'hF, 32'hE3A01005};
        vecs[1] = '{1'b0, 1'b0, 4'h1, 32'h300, 32'h0, 2, 32'h12345678, 4, 4'hF, 32'h12345678};
        vecs[2] = '{1'b0, 1'b1, 4'h3, 32'h200, 32'hCAFEF00D, 1, 32'h99999999, 3, 4'h3, 32'h12345678};
        vecs[3] = '{1'b1, 1'b0, 4'h0, 32'h104, 32'h0, 4, 32'hAABBCCDD, 6, 4'hF, 32'hAABBCCDD};
        vecs[4] = '{1'b0, 1'b1, 4'hC, 32'h204, 32'h01020304, 3, 32'h77777777, 5, 4'hC, 32'h12345678};
        vecs[5] = '{1'b0, 1'b0, 4'hF, 32'h208, 32'h0, 5, 32'h55AA55AA, 7, 4'hF, 32'h55AA55AA};

        reset           = 1'b0;
        bus_if.if_req   = 1'b1;
        bus_if.if_addr  = 32'h0;
        bus_if.dm_req   = 1'b0;
        bus_if.dm_we    = 1'b0;
        bus_if.dm_be    = 4'h0;
        bus_if.dm_addr  = 32'h0;
        bus_if.dm_wdata = 32'h0;
        for (int i = 0; i < 64; i++) rd_vals[i] = 32'h0;

        // Outputs while reset is held, with a fetch request already pending
        repeat (2) @(negedge clk);
        chk("rst mem_req",  32'(bus_if.mem_req),  32'd0);
        chk("rst if_ready", 32'(bus_if.if_ready), 32'd0);
        chk("rst dm_ready", 32'(bus_if.dm_ready), 32'd0);
        chk("rst stall_f",  32'(bus_if.stall_f),  32'd0);
        chk("rst bus_err",  32'(bus_if.bus_err),  32'd0);
        chk("rst if_rdata", bus_if.if_rdata, 32'h0);
        chk("rst dm_rdata", bus_if.dm_rdata, 32'h0);
        bus_if.if_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Simultaneous store and fetch: store first, fetch in the next IDLE
        mem_lat = 1; mem_hang = 1'b0; rd_idx = 0;
        rd_vals[0] = 32'h5A5A5A5A; rd_vals[1] = 32'hE1A00000;
        @(negedge clk);
        bus_if.if_req  = 1'b1; bus_if.if_addr = 32'h104;
        bus_if.dm_req  = 1'b1; bus_if.dm_we   = 1'b1; bus_if.dm_be = 4'b0011;
        bus_if.dm_addr = 32'h200; bus_if.dm_wdata = 32'hCAFEF00D;
        n = 0; d_at = 0; i_at = 0; f_at = 0;
        while (i_at == 0 && n < 300) begin
            @(negedge clk);
            n = n + 1;
            if (n == 1) begin
                chk("sim mem_we",   32'(bus_if.mem_we), 32'd1);
                chk("sim mem_be",   32'(bus_if.mem_be), 32'h3);
                chk("sim mem_addr", bus_if.mem_addr, 32'h200);
            end
            if (bus_if.mem_req && bus_if.mem_addr == 32'h104 && f_at == 0) f_at = n;
            if (bus_if.dm_ready) begin d_at = n; bus_if.dm_req = 1'b0; end
            if (bus_if.if_ready) begin
                i_at = n;
                chk("sim if_rdata", bus_if.if_rdata, 32'hE1A00000);
                bus_if.if_req = 1'b0;
            end
        end
        if (i_at == 0) bound_fail("sim fetch_timeout");
        chk("sim dm_ready_cycle",  32'(d_at), 32'd3);
        chk("sim fetch_req_cycle", 32'(f_at), 32'd5);
        chk("sim if_ready_cycle",  32'(i_at), 32'd7);
        bus_if.if_req = 1'b0; bus_if.dm_req = 1'b0;

        // Continuous data and fetch requests: 4 data grants then 1 fetch, repeating
        mem_lat = 1; rd_idx = 0;
        @(negedge clk);
        bus_if.dm_req = 1'b1; bus_if.dm_we = 1'b0; bus_if.dm_addr = 32'h400;
        bus_if.if_req = 1'b1; bus_if.if_addr = 32'h108;
        n = 0; got = 0;
        while (got < 10 && n < 600) begin
            @(negedge clk);
            n = n + 1;
            if (bus_if.dm_ready || bus_if.if_ready) begin
                exp_i = ((got % 5) == 4);
                chk($sformatf("burst grant%0d {dm,if}", got),
                    32'({bus_if.dm_ready, bus_if.if_ready}), 32'({~exp_i, exp_i}));
                got = got + 1;
            end
        end
        if (got < 10) bound_fail("burst timeout");
        bus_if.dm_req = 1'b0; bus_if.if_req = 1'b0;

        // Hung memory on a load: watchdog completes it with ERR_DATA
        chk("wd bus_err_before", 32'(bus_if.bus_err), 32'd0);
        mem_hang = 1'b1;
        @(negedge clk);
        bus_if.dm_req = 1'b1; bus_if.dm_we = 1'b0; bus_if.dm_addr = 32'h500;
        n = 0; d_at = 0;
        while (d_at == 0 && n < 300) begin
            @(negedge clk);
            n = n + 1;
            if (bus_if.dm_ready) begin
                d_at = n;
                chk("wd dm_rdata", bus_if.dm_rdata, c_ERR);
                chk("wd bus_err",  32'(bus_if.bus_err), 32'd1);
                chk("wd mem_req_dropped", 32'(bus_if.mem_req), 32'd0);
                bus_if.dm_req = 1'b0;
            end
        end
        if (d_at == 0) bound_fail("wd ready_timeout");
        chk("wd ready_cycle", 32'(d_at), 32'd10);
        bus_if.dm_req = 1'b0;
        mem_hang = 1'b0;
        run_vec(vecs[0], 10);
        chk("wd bus_err_sticky", 32'(bus_if.bus_err), 32'd1);

        // Reset asserted in the middle of a fetch
        mem_lat = 5; rd_idx = 0;
        @(negedge clk);
        bus_if.if_req = 1'b1; bus_if.if_addr = 32'h700;
        repeat (3) @(negedge clk);
        chk("rst5 mem_req_before", 32'(bus_if.mem_req), 32'd1);
        reset = 1'b0;
        #1;
        chk("rst5 mem_req",  32'(bus_if.mem_req),  32'd0);
        chk("rst5 if_ready", 32'(bus_if.if_ready), 32'd0);
        chk("rst5 stall_f",  32'(bus_if.stall_f),  32'd0);
        chk("rst5 bus_err",  32'(bus_if.bus_err),  32'd0);
        bus_if.if_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus_if.if_ready || bus_if.mem_req) pulses = pulses + 1;
        end
        chk("rst5 no_stale_activity", 32'(pulses), 32'd0);
        run_vec(vecs[3], 11);

        // Back-to-back loads with the request held across the first completion
        mem_lat = 3; rd_idx = 0;
        rd_vals[0] = 32'h11; rd_vals[1] = 32'h22; rd_vals[2] = 32'h33;
        @(negedge clk);
        bus_if.dm_req = 1'b1; bus_if.dm_we = 1'b0; bus_if.dm_addr = 32'h600;
        pulses = 0; rises = 0; prev_req = 1'b0; n1 = 0; n2 = 0; v1 = '0; v2 = '0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (bus_if.mem_req && !prev_req) rises = rises + 1;
            prev_req = bus_if.mem_req;
            if (bus_if.dm_ready) begin
                pulses = pulses + 1;
                if (pulses == 1) begin n1 = c; v1 = bus_if.dm_rdata; end
                if (pulses == 2) begin n2 = c; v2 = bus_if.dm_rdata; bus_if.dm_req = 1'b0; end
            end
        end
        bus_if.dm_req = 1'b0;
        chk("b2b first_cycle", 32'(n1), 32'd5);
        chk("b2b spacing",     32'(n2 - n1), 32'd6);
        chk("b2b rdata1", v1, 32'h11);
        chk("b2b rdata2", v2, 32'h22);
        chk("b2b pulses", 32'(pulses), 32'd2);
        chk("b2b grants", 32'(rises),  32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
